// File: rtl/mem_access_ctrl_if.sv
// Memory-side bus of the LC-3 memory-access sequencer: MAR-driven address,
// MDR write data, read/write request strobes held until ack, and read data return.
interface mem_access_ctrl_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_rd;
   logic              mem_wr;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output mem_addr, mem_wdata, mem_rd, mem_wr,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_rd, mem_wr,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// LC-3 MAR/MDR memory-access sequencer for LD/ST, LDR/STR and LDI/STI.
// Optional macro MEM_TIMEOUT_EN adds a per-access wait counter that ends a stalled access with err.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for start; request captured on the start edge
// PTR_RD  | indirect pointer fetch; ack loads the pointer into MAR
// DATA_RD | data read at MAR; ack loads MDR (rdata)
// DATA_WR | data write of captured store data to MAR
// DONE    | one-cycle completion pulse (err on timeout)
module mem_access_ctrl #(
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              Clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op_write,
   input  logic              op_indirect,
   input  logic [DATA_W-1:0] ea_in,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] mar,
   mem_access_ctrl_if.master mem
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PTR_RD  = 3'd1,
      ST_DATA_RD = 3'd2,
      ST_DATA_WR = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              wr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              waiting;
   logic              timeout_hit;

   assign waiting = (state == ST_PTR_RD) || (state == ST_DATA_RD) || (state == ST_DATA_WR);

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   // Hit is evaluated on the edge that would complete the TIMEOUT-th unacked cycle; ack still wins.
   assign timeout_hit = waiting && (wait_cnt == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge Clk) begin
      if (!reset) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if (state_nxt != state)
            wait_cnt <= '0;
         else if (waiting && !mem.mem_ack)
            wait_cnt <= wait_cnt + 1'b1;

         if (state == ST_IDLE)
            err_q <= 1'b0;
         else if (timeout_hit && !mem.mem_ack)
            err_q <= 1'b1;
      end
   end

   assign err = (state == ST_DONE) && err_q;
`else
   assign timeout_hit = 1'b0;
   assign err         = 1'b0;
`endif

   always_ff @(posedge Clk) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (op_indirect)   state_nxt = ST_PTR_RD;
               else if (op_write) state_nxt = ST_DATA_WR;
               else               state_nxt = ST_DATA_RD;
            end
         end
         ST_PTR_RD: begin
            if (mem.mem_ack)      state_nxt = wr_q ? ST_DATA_WR : ST_DATA_RD;
            else if (timeout_hit) state_nxt = ST_DONE;
         end
         ST_DATA_RD,
         ST_DATA_WR: begin
            if (mem.mem_ack || timeout_hit) state_nxt = ST_DONE;
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!reset) begin
         mar     <= '0;
         rdata   <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  mar     <= ea_in;
                  wdata_q <= wdata;
                  wr_q    <= op_write;
               end
            end
            ST_PTR_RD:  if (mem.mem_ack) mar   <= mem.mem_rdata;
            ST_DATA_RD: if (mem.mem_ack) rdata <= mem.mem_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      busy        = (state != ST_IDLE);
      done        = (state == ST_DONE);
      mem.mem_rd  = (state == ST_PTR_RD) || (state == ST_DATA_RD);
      mem.mem_wr  = (state == ST_DATA_WR);
   end

   assign mem.mem_addr  = mar;
   assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed latency, address and data expectations.
module tb_mem_access_ctrl;

`ifdef MEM_TIMEOUT_EN
   localparam int TB_TO = 4;
`else
   localparam int TB_TO = 255;
`endif
   localparam int KPTR = 0;
   localparam int KRD  = 1;
   localparam int KWR  = 2;

   logic        Clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        op_write = 1'b0;
   logic        op_indirect = 1'b0;
   logic [15:0] ea_in = '0;
   logic [15:0] wdata = '0;
   logic        busy, done, err;
   logic [15:0] rdata, mar;

   mem_access_ctrl_if #(.DATA_W(16)) mem ();

   mem_access_ctrl #(.DATA_W(16), .TIMEOUT(TB_TO)) dut (
      .Clk(Clk), .reset(reset), .start(start), .op_write(op_write),
      .op_indirect(op_indirect), .ea_in(ea_in), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata), .mar(mar),
      .mem(mem)
   );

   always #5 Clk = ~Clk;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- memory responder ----------------
   int  tb_waits = 0;
   bit  tb_noack = 0;
   bit  tb_stray = 0;
   int  wcnt = 0;

   function automatic logic [15:0] rd_lookup(input logic [15:0] a);
      case (a)
         16'h3010: return 16'hBEEF;
         16'h0010: return 16'hFFFF;
         16'hFFFF: return 16'h00A5;
         16'h0020: return 16'h0000;
         default:  return a ^ 16'h5A5A;
      endcase
   endfunction

   initial begin
      mem.mem_ack   = 1'b0;
      mem.mem_rdata = '0;
   end

   always @(negedge Clk) begin
      if (tb_stray) begin
         mem.mem_ack = 1'b1;
      end else if ((mem.mem_rd || mem.mem_wr) && !tb_noack) begin
         if (wcnt >= tb_waits) begin
            mem.mem_ack = 1'b1;
            wcnt = 0;
         end else begin
            mem.mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem.mem_ack = 1'b0;
         wcnt = 0;
      end
      mem.mem_rdata = rd_lookup(mem.mem_addr);
   end

   logic [15:0] acc_addr [$];
   always @(posedge Clk)
      if (reset && mem.mem_ack && (mem.mem_rd || mem.mem_wr))
         acc_addr.push_back(mem.mem_addr);

   // ---------------- transaction-level reference model ----------------
   bit          m_valid = 0;
   int          q [$];
   bit          m_done = 0;
   bit          m_err = 0;
   int          m_wait = 0;
   logic [15:0] m_mar = '0, m_rdata = '0, m_wdata = '0;

   always @(posedge Clk) begin
      if (!reset) begin
         m_valid = 1;
         q.delete();
         m_done = 0; m_err = 0; m_wait = 0;
         m_mar = '0; m_rdata = '0; m_wdata = '0;
      end else if (m_done) begin
         m_done = 0;
         m_err  = 0;
      end else if (q.size() == 0) begin
         if (start) begin
            m_mar   = ea_in;
            m_wdata = wdata;
            m_wait  = 0;
            if (op_indirect) q.push_back(KPTR);
            q.push_back(op_write ? KWR : KRD);
         end
      end else if (mem.mem_ack) begin
         if (q[0] == KPTR) m_mar   = mem.mem_rdata;
         if (q[0] == KRD)  m_rdata = mem.mem_rdata;
         void'(q.pop_front());
         m_wait = 0;
         if (q.size() == 0) m_done = 1;
      end else begin
`ifdef MEM_TIMEOUT_EN
         m_wait++;
         if (m_wait == TB_TO) begin
            q.delete();
            m_done = 1;
            m_err  = 1;
         end
`endif
      end
   end

   always @(negedge Clk) begin
      if (m_valid) begin
         chk("busy",      busy,          (q.size() > 0) || m_done);
         chk("done",      done,          m_done);
         chk("err",       err,           m_done && m_err);
         chk("mar",       mar,           m_mar);
         chk("mem_addr",  mem.mem_addr,  m_mar);
         chk("rdata",     rdata,         m_rdata);
         chk("mem_wdata", mem.mem_wdata, m_wdata);
         chk("mem_rd",    mem.mem_rd,    (q.size() > 0) && (q[0] != KWR));
         chk("mem_wr",    mem.mem_wr,    (q.size() > 0) && (q[0] == KWR));
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic run_txn(input bit w, input bit ind, input logic [15:0] ea, input logic [15:0] wd,
                          input int waits, output int lat, output int wr_cyc);
      tb_waits = waits;
      acc_addr.delete();
      @(negedge Clk);
      start = 1'b1; op_write = w; op_indirect = ind; ea_in = ea; wdata = wd;
      @(negedge Clk);
      start = 1'b0; ea_in = 16'h7777; wdata = 16'h9999;
      lat = 1;
      wr_cyc = 0;
      while (!done && lat < 60) begin
         if (mem.mem_wr) wr_cyc++;
         @(negedge Clk);
         lat++;
      end
      if (!done) begin
         n_checks++;
         n_err++;
         $display("FAIL txn_wait: no done within %0d cycles", lat);
      end
   endtask

   int  lat, wr_cyc;
   bit  saw_done;

   initial begin
      // reset held with start asserted
      reset = 1'b0; start = 1'b1; op_write = 1'b1; ea_in = 16'h1111; wdata = 16'h2222;
      @(negedge Clk);
      @(negedge Clk);
      chk("rst_busy",   busy, 0);
      chk("rst_done",   done, 0);
      chk("rst_err",    err, 0);
      chk("rst_strobe", {mem.mem_rd, mem.mem_wr}, 0);
      chk("rst_mar",    mar, 16'h0000);
      chk("rst_rdata",  rdata, 16'h0000);
      chk("rst_wdata",  mem.mem_wdata, 16'h0000);
      start = 1'b0; op_write = 1'b0;
      reset = 1'b1;

      // stray ack while idle
      tb_stray = 1;
      @(negedge Clk);
      @(negedge Clk);
      tb_stray = 0;
      chk("idle_ack_busy", busy, 0);

      // direct load, zero wait
      run_txn(0, 0, 16'h3010, 16'h0000, 0, lat, wr_cyc);
      chk("ld_lat",   lat, 2);
      chk("ld_rdata", rdata, 16'hBEEF);
      chk("ld_nacc",  acc_addr.size(), 1);
      if (acc_addr.size() >= 1) chk("ld_addr", acc_addr[0], 16'h3010);
      chk("ld_err",   err, 0);

      // store with 3 wait cycles
      run_txn(1, 0, 16'h4000, 16'h1234, 3, lat, wr_cyc);
      chk("st_lat",    lat, 5);
      chk("st_wrcyc",  wr_cyc, 4);
      chk("st_wdata",  mem.mem_wdata, 16'h1234);
      chk("st_rdata",  rdata, 16'hBEEF);
      if (acc_addr.size() >= 1) chk("st_addr", acc_addr[0], 16'h4000);

      // indirect load, pointer FFFF
      run_txn(0, 1, 16'h0010, 16'h0000, 0, lat, wr_cyc);
      chk("ldi_lat",   lat, 3);
      chk("ldi_nacc",  acc_addr.size(), 2);
      if (acc_addr.size() >= 2) begin
         chk("ldi_addr0", acc_addr[0], 16'h0010);
         chk("ldi_addr1", acc_addr[1], 16'hFFFF);
      end
      chk("ldi_rdata", rdata, 16'h00A5);
      chk("ldi_mar",   mar, 16'hFFFF);

      // indirect store, pointer 0000, one wait per access
      run_txn(1, 1, 16'h0020, 16'hCAFE, 1, lat, wr_cyc);
      chk("sti_lat",   lat, 5);
      chk("sti_wrcyc", wr_cyc, 2);
      if (acc_addr.size() >= 2) chk("sti_addr1", acc_addr[1], 16'h0000);
      chk("sti_rdata", rdata, 16'h00A5);

      // start re-pulsed in DATA_RD and in DONE must be ignored
      tb_waits = 2;
      acc_addr.delete();
      @(negedge Clk);
      start = 1'b1; op_write = 1'b0; op_indirect = 1'b0; ea_in = 16'h3010;
      @(negedge Clk);
      ea_in = 16'h5555; op_write = 1'b1;
      lat = 1;
      @(negedge Clk);
      start = 1'b0;
      lat = 2;
      while (!done && lat < 60) begin
         @(negedge Clk);
         lat++;
      end
      chk("busy_lat", lat, 4);
      start = 1'b1; op_write = 1'b1; ea_in = 16'h6666;
      @(negedge Clk);
      start = 1'b0;
      chk("done_start_ignored", busy, 0);
      @(negedge Clk);
      chk("done_start_idle", busy, 0);
      chk("busy_nacc", acc_addr.size(), 1);
      chk("busy_mar",  mar, 16'h3010);

      // reset mid-wait aborts with no done pulse
      tb_waits = 3;
      saw_done = 0;
      @(negedge Clk);
      start = 1'b1; op_write = 1'b0; ea_in = 16'h4444;
      @(negedge Clk);
      start = 1'b0;
      if (done) saw_done = 1;
      @(negedge Clk);
      if (done) saw_done = 1;
      reset = 1'b0;
      @(negedge Clk);
      reset = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_rdata", rdata, 16'h0000);
      for (int i = 0; i < 4; i++) begin
         if (done) saw_done = 1;
         @(negedge Clk);
      end
      chk("abort_nodone", saw_done, 0);

`ifdef MEM_TIMEOUT_EN
      run_txn(0, 0, 16'h3010, 16'h0000, 0, lat, wr_cyc);
      chk("pre_to_rdata", rdata, 16'hBEEF);
      tb_noack = 1;
      run_txn(0, 0, 16'h2000, 16'h0000, 0, lat, wr_cyc);
      chk("to_lat",   lat, 5);
      chk("to_err",   err, 1);
      chk("to_rdata", rdata, 16'hBEEF);
      run_txn(0, 1, 16'h2100, 16'h0000, 0, lat, wr_cyc);
      chk("to_ptr_lat", lat, 5);
      chk("to_ptr_err", err, 1);
      chk("to_ptr_mar", mar, 16'h2100);
      tb_noack = 0;
      run_txn(0, 0, 16'h3010, 16'h0000, 0, lat, wr_cyc);
      chk("post_to_err", err, 0);
`endif

      @(negedge Clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
